// File: rtl/phy_reg_commit_writer.sv
// rtl/phy_reg_commit_writer.sv - ALU/MEM result buffer driving the physical regfile commit write port
// Optional first-result bypass around the FIFO: COMMIT_WRITER_BYPASS_EN.
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module phy_reg_commit_writer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  logic                               alu_valid,
   output logic                               alu_ready,
   input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] alu_dst_reg,
   input  logic [`REG_VAL_WIDTH-1:0]          alu_val,
   input  logic                               alu_reg_wb,
   input  logic                               mem_valid,
   output logic                               mem_ready,
   input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] mem_dst_reg,
   input  logic [`REG_VAL_WIDTH-1:0]          mem_val,
   input  logic                               mem_reg_wb,
   output logic                               commit_wr_en,
   output logic [`PHYSICAL_REG_NUM_WIDTH-1:0] wr_commit_reg,
   output logic [`REG_VAL_WIDTH-1:0]          commit_wr_val,
   output logic [CNT_W-1:0]                   fifo_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int RW    = `PHYSICAL_REG_NUM_WIDTH;
   localparam int VW    = `REG_VAL_WIDTH;

   logic [RW-1:0]    reg_mem [DEPTH];
   logic [VW-1:0]    val_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, free, mem_need;
   logic             alu_real, mem_real, alu_enq, mem_enq;
   logic             alu_q, mem_q, bypass_alu, bypass_mem, deq;

   // Null results (no writeback or r0 target) are swallowed and never need a slot.
   assign alu_real  = alu_reg_wb && (alu_dst_reg != '0);
   assign mem_real  = mem_reg_wb && (mem_dst_reg != '0);
   assign free      = CNT_W'(DEPTH) - count;
   assign mem_need  = CNT_W'(1) + CNT_W'(alu_valid && alu_real);
   assign alu_ready = !flush && (!alu_real || (free >= CNT_W'(1)));
   assign mem_ready = !flush && (!mem_real || (free >= mem_need));
   assign alu_enq   = alu_valid && alu_ready && alu_real;
   assign mem_enq   = mem_valid && mem_ready && mem_real;
   assign deq       = !flush && (count != '0);

`ifdef COMMIT_WRITER_BYPASS_EN
   assign bypass_alu = !flush && (count == '0) && alu_enq;
   assign bypass_mem = !flush && (count == '0) && mem_enq && !alu_enq;
`else
   assign bypass_alu = 1'b0;
   assign bypass_mem = 1'b0;
`endif

   assign alu_q      = alu_enq && !bypass_alu;
   assign mem_q      = mem_enq && !bypass_mem;
   assign fifo_count = count;

   // ALU takes the lower slot; MEM lands one above when both enqueue.
   always_ff @(posedge clk) begin
      if (alu_q) begin
         reg_mem[wr_ptr] <= alu_dst_reg;
         val_mem[wr_ptr] <= alu_val;
      end
      if (mem_q) begin
         reg_mem[wr_ptr + PTR_W'(alu_q)] <= mem_dst_reg;
         val_mem[wr_ptr + PTR_W'(alu_q)] <= mem_val;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(alu_q) + PTR_W'(mem_q);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         count  <= count + CNT_W'(alu_q) + CNT_W'(mem_q) - CNT_W'(deq);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         commit_wr_en  <= 1'b0;
         wr_commit_reg <= '0;
         commit_wr_val <= '0;
      end else if (flush) begin
         commit_wr_en <= 1'b0;
      end else if (deq) begin
         commit_wr_en  <= 1'b1;
         wr_commit_reg <= reg_mem[rd_ptr];
         commit_wr_val <= val_mem[rd_ptr];
      end else if (bypass_alu) begin
         commit_wr_en  <= 1'b1;
         wr_commit_reg <= alu_dst_reg;
         commit_wr_val <= alu_val;
      end else if (bypass_mem) begin
         commit_wr_en  <= 1'b1;
         wr_commit_reg <= mem_dst_reg;
         commit_wr_val <= mem_val;
      end else begin
         commit_wr_en <= 1'b0;
      end
   end
endmodule

// File: tb/tb_phy_reg_commit_writer.sv
// tb/tb_phy_reg_commit_writer.sv - scoreboard bench for phy_reg_commit_writer
`timescale 1ns/1ps
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

module tb_phy_reg_commit_writer;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int RW    = `PHYSICAL_REG_NUM_WIDTH;
   localparam int VW    = `REG_VAL_WIDTH;

   logic             clk = 1'b0;
   logic             reset, flush;
   logic             alu_valid, alu_ready, alu_reg_wb;
   logic [RW-1:0]    alu_dst_reg;
   logic [VW-1:0]    alu_val;
   logic             mem_valid, mem_ready, mem_reg_wb;
   logic [RW-1:0]    mem_dst_reg;
   logic [VW-1:0]    mem_val;
   logic             commit_wr_en;
   logic [RW-1:0]    wr_commit_reg;
   logic [VW-1:0]    commit_wr_val;
   logic [CNT_W-1:0] fifo_count;

   always #5 clk = ~clk;

   phy_reg_commit_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst_reg(alu_dst_reg),
      .alu_val(alu_val), .alu_reg_wb(alu_reg_wb),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst_reg(mem_dst_reg),
      .mem_val(mem_val), .mem_reg_wb(mem_reg_wb),
      .commit_wr_en(commit_wr_en), .wr_commit_reg(wr_commit_reg),
      .commit_wr_val(commit_wr_val), .fifo_count(fifo_count)
   );

   typedef struct packed {
      logic [RW-1:0] r;
      logic [VW-1:0] v;
   } wr_t;

   wr_t  sb[$];
   wr_t  mon_e;
   int   checks = 0;
   int   errors = 0;
   int   mcount = 0;
   logic exp_wr = 1'b0;
   logic mon_en = 1'b0;

   // Write-side scoreboard: registered outputs sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (commit_wr_en !== exp_wr) begin
            errors++;
            $display("FAIL wr_en_timing: got %b expected %b at %0t", commit_wr_en, exp_wr, $time);
         end
         if (commit_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: got reg %0d val %h expected no write", wr_commit_reg, commit_wr_val);
            end else begin
               mon_e = sb.pop_front();
               checks++;
               if ({wr_commit_reg, commit_wr_val} !== mon_e) begin
                  errors++;
                  $display("FAIL write_data: got reg %0d val %h expected reg %0d val %h",
                           wr_commit_reg, commit_wr_val, mon_e.r, mon_e.v);
               end
            end
         end
      end
   end

   task automatic drive(input logic av, input logic [RW-1:0] ad, input logic [VW-1:0] avl, input logic awb,
                        input logic mv, input logic [RW-1:0] md, input logic [VW-1:0] mvl, input logic mwb,
                        input logic fl);
      logic an, ar, mn, ear, emr, aenq, menq, deq, byp;
      @(negedge clk);
      #2;
      alu_valid = av; alu_dst_reg = ad; alu_val = avl; alu_reg_wb = awb;
      mem_valid = mv; mem_dst_reg = md; mem_val = mvl; mem_reg_wb = mwb;
      flush = fl;
      #1;
      an  = !(awb && (ad != '0));
      ar  = av && !an;
      mn  = !(mwb && (md != '0));
      ear = !fl && (an || (mcount < DEPTH));
      emr = !fl && (mn || ((mcount + int'(ar)) < DEPTH));
      checks += 3;
      if (alu_ready !== ear) begin
         errors++;
         $display("FAIL alu_ready: got %b expected %b (count %0d)", alu_ready, ear, mcount);
      end
      if (mem_ready !== emr) begin
         errors++;
         $display("FAIL mem_ready: got %b expected %b (count %0d)", mem_ready, emr, mcount);
      end
      if (fifo_count !== CNT_W'(mcount)) begin
         errors++;
         $display("FAIL fifo_count: got %0d expected %0d", fifo_count, mcount);
      end
      aenq = av && ear && !an;
      menq = mv && emr && !mn;
      deq  = (mcount != 0) && !fl;
      byp  = 1'b0;
`ifdef COMMIT_WRITER_BYPASS_EN
      byp  = (mcount == 0) && !fl && (aenq || menq);
`endif
      exp_wr = deq || byp;
      if (fl) begin
         sb.delete();
         mcount = 0;
      end else begin
         if (aenq) sb.push_back({ad, avl});
         if (menq) sb.push_back({md, mvl});
         mcount = mcount + int'(aenq) + int'(menq) - int'(byp) - int'(deq);
      end
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < DEPTH + 3; k++) idle();
   endtask

   task automatic test_reset();
      reset = 1'b0; flush = 1'b0;
      alu_valid = 1'($urandom); alu_reg_wb = 1'($urandom); alu_dst_reg = RW'($urandom); alu_val = VW'($urandom);
      mem_valid = 1'($urandom); mem_reg_wb = 1'($urandom); mem_dst_reg = RW'($urandom); mem_val = VW'($urandom);
      repeat (2) @(posedge clk);
      #1;
      checks += 6;
      if (commit_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", commit_wr_en); end
      if (wr_commit_reg !== '0) begin errors++; $display("FAIL reset_reg: got %0d expected 0", wr_commit_reg); end
      if (commit_wr_val !== '0) begin errors++; $display("FAIL reset_val: got %h expected 0", commit_wr_val); end
      if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
      if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b expected 1", alu_ready); end
      if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %b expected 1", mem_ready); end
      @(negedge clk);
      #2;
      alu_valid = 1'b0; mem_valid = 1'b0;
      reset = 1'b1;
      mcount = 0; exp_wr = 1'b0; sb.delete();
      mon_en = 1'b1;
   endtask

   task automatic test_single();
      drive(1'b1, RW'(5), VW'(32'hDEAD), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checks++;
`ifdef COMMIT_WRITER_BYPASS_EN
      if (commit_wr_en !== 1'b1 || wr_commit_reg !== RW'(5) || commit_wr_val !== VW'(32'hDEAD)) begin
         errors++;
         $display("FAIL single_bypass: got en %b reg %0d val %h expected 1 5 dead", commit_wr_en, wr_commit_reg, commit_wr_val);
      end
`else
      if (commit_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL single_edge1: got en %b expected 0", commit_wr_en);
      end
`endif
      idle();
      @(posedge clk);
      #1;
      checks++;
`ifdef COMMIT_WRITER_BYPASS_EN
      if (commit_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL single_edge2: got en %b expected 0", commit_wr_en);
      end
`else
      if (commit_wr_en !== 1'b1 || wr_commit_reg !== RW'(5) || commit_wr_val !== VW'(32'hDEAD)) begin
         errors++;
         $display("FAIL single_edge2: got en %b reg %0d val %h expected 1 5 dead", commit_wr_en, wr_commit_reg, commit_wr_val);
      end
`endif
      drain();
   endtask

   task automatic test_back_to_back();
      logic throttled = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, RW'(i + 1), VW'(32'hA000 + i), 1'b1, 1'b1, RW'(i + 17), VW'(32'hB000 + i), 1'b1, 1'b0);
         if (mem_ready === 1'b0) throttled = 1'b1;
      end
      checks++;
      if (throttled !== 1'b1) begin
         errors++;
         $display("FAIL b2b_throttle: got %b expected 1", throttled);
      end
      drain();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic test_null_results();
      for (int i = 0; i < 3; i++)
         drive(1'b1, RW'(i + 3), VW'(32'hC000 + i), 1'b1, 1'b1, RW'(i + 40), VW'(32'hC100 + i), 1'b1, 1'b0);
      drive(1'b1, RW'(7), VW'(32'hD001), 1'b1, 1'b1, RW'(0), VW'(32'hBAD0), 1'b1, 1'b0);
      drive(1'b1, RW'(8), VW'(32'hD002), 1'b1, 1'b1, RW'(9), VW'(32'hBAD1), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checks++;
      if (fifo_count !== CNT_W'(3)) begin
         errors++;
         $display("FAIL null_count: got %0d expected 3", fifo_count);
      end
      drain();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++)
         drive(1'b1, RW'(i + 10), VW'(32'hE000 + i), 1'b1, 1'b1, RW'(i + 50), VW'(32'hE100 + i), 1'b1, 1'b0);
      drive(1'b1, RW'(30), VW'(32'hF00D), 1'b1, 1'b1, RW'(31), VW'(32'hF00E), 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checks += 2;
      if (fifo_count !== '0) begin errors++; $display("FAIL flush_count: got %0d expected 0", fifo_count); end
      if (commit_wr_en !== 1'b0) begin errors++; $display("FAIL flush_wr_en: got %b expected 0", commit_wr_en); end
      drain();
   endtask

   task automatic test_reset_mid();
      drive(1'b1, RW'(12), VW'(32'h1234), 1'b1, 1'b1, RW'(13), VW'(32'h5678), 1'b1, 1'b0);
      @(negedge clk);
      #2;
      reset = 1'b0;
      alu_valid = 1'b0; mem_valid = 1'b0;
      #1;
      sb.delete(); mcount = 0; exp_wr = 1'b0;
      checks += 2;
      if (fifo_count !== '0) begin errors++; $display("FAIL midreset_count: got %0d expected 0", fifo_count); end
      if (commit_wr_en !== 1'b0) begin errors++; $display("FAIL midreset_wr_en: got %b expected 0", commit_wr_en); end
      @(negedge clk);
      #2;
      reset = 1'b1;
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++)
         drive(1'($urandom), RW'($urandom_range(0, 3)), VW'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom), RW'($urandom_range(0, 3)), VW'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 9) == 0));
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_null_results();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
